// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: debounces two push-buttons and drives clean, mutually
// exclusive, fixed-width S/R pulses into a NOR SR latch, then reads the
// latch Q back after each pulse and flags a sticky error on mismatch.
module sr_pulse_driver #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  input  logic q_fb,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic err,
  output logic last_cmd
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TCW  = $clog2(TMAX + 1);
  localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCW-1:0] PULSE_LAST = TCW'(PULSE_CYCLES - 1);
  localparam logic [TCW-1:0] GAP_LAST   = TCW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_e;

  // Channel 0 carries the set button, channel 1 the reset button.
  logic [1:0]          btn_raw;
  logic [1:0]          meta_q, sync_q;
  logic                qmeta_q, qsync_q;
  logic [1:0][DCW-1:0] cnt_q, cnt_d;
  logic [1:0]          stab_q, stab_d, stab_prev_q;
  logic [1:0]          pend_q, pend_d;
  logic [1:0]          rise;
  logic                take_s, take_r;
  state_e              state_q;
  logic [TCW-1:0]      tmr_q;

  assign btn_raw = {reset_btn, set_btn};

  // Two-flop synchronisers for both buttons and the latch readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      qmeta_q <= 1'b0;
      qsync_q <= 1'b0;
    end else begin
      meta_q  <= btn_raw;
      sync_q  <= meta_q;
      qmeta_q <= q_fb;
      qsync_q <= qmeta_q;
    end
  end

  // Debounce next-state: count consecutive disagreeing cycles, flip on the last.
  always_comb begin
    cnt_d  = '0;
    stab_d = stab_q;
    for (int c = 0; c < 2; c++) begin
      if (sync_q[c] != stab_q[c]) begin
        if (cnt_q[c] == DEB_LAST) stab_d[c] = ~stab_q[c];
        else                      cnt_d[c]  = cnt_q[c] + 1'b1;
      end
    end
  end

  // Only rising stable edges become requests; reset wins and drops a set.
  assign rise   = stab_q & ~stab_prev_q;
  assign take_r = (state_q == IDLE) & pend_q[1];
  assign take_s = (state_q == IDLE) & ~pend_q[1] & pend_q[0];
  assign pend_d[0] = (pend_q[0] & ~(take_s | take_r)) | rise[0];
  assign pend_d[1] = (pend_q[1] & ~take_r) | rise[1];

  // Debounce state, edge history and pending request flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      stab_q      <= '0;
      stab_prev_q <= '0;
      pend_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      stab_prev_q <= stab_q;
      pend_q      <= pend_d;
    end
  end

  // Pulse sequencer with registered outputs; Q is checked on the last gap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      last_cmd <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (take_r) begin
            state_q  <= PULSE_R;
            r_out    <= 1'b1;
            busy     <= 1'b1;
            last_cmd <= 1'b0;
          end else if (take_s) begin
            state_q  <= PULSE_S;
            s_out    <= 1'b1;
            busy     <= 1'b1;
            last_cmd <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          if (tmr_q == PULSE_LAST) begin
            state_q <= GAP;
            s_out   <= 1'b0;
            r_out   <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        GAP: begin
          if (tmr_q == GAP_LAST) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            tmr_q   <= '0;
            if (qsync_q != last_cmd) err <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: scenario tasks plus a random run, all checked
// against a window/timeline reference model and a behavioural NOR latch.
module tb_sr_pulse_driver;

  localparam int DEB  = 4;
  localparam int PUL  = 2;
  localparam int GAP  = 3;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst, set_btn, reset_btn, q_fb;
  logic s_out, r_out, busy, err, last_cmd;

  int n_chk  = 0;
  int n_fail = 0;
  bit stuck  = 1'b0;

  // Reference model: raw input history per edge, stable-level history,
  // and a command timeline (start edge + kind).
  int e;
  bit raw [2][HMAX];
  bit stb [2][HMAX];
  bit qh  [HMAX];
  bit m_pend [2];
  int m_start;
  bit m_cmd, m_err, m_last, m_busy;

  sr_pulse_driver #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn), .q_fb(q_fb),
    .s_out(s_out), .r_out(r_out), .busy(busy), .err(err), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  // Synchronised level seen after edge m is the raw value sampled at edge m-1.
  function automatic bit sync_at(int c, int m);
    return (m >= 1) ? raw[c][m-1] : 1'b0;
  endfunction

  task automatic model_step(input bit r);
    bit all;
    if (r) begin
      e = 0; m_pend[0] = 0; m_pend[1] = 0; m_start = -100;
      m_err = 0; m_last = 0; m_busy = 0; m_cmd = 0;
      raw[0][0] = 0; raw[1][0] = 0; stb[0][0] = 0; stb[1][0] = 0; qh[0] = 0;
      return;
    end
    e++;
    raw[0][e] = set_btn; raw[1][e] = reset_btn; qh[e] = q_fb;
    if (!m_busy) begin
      if (m_pend[1]) begin
        m_start = e; m_cmd = 0; m_last = 0; m_pend[0] = 0; m_pend[1] = 0;
      end else if (m_pend[0]) begin
        m_start = e; m_cmd = 1; m_last = 1; m_pend[0] = 0;
      end
    end
    if (e == m_start + PUL + GAP && qh[e-2] != m_last) m_err = 1;
    for (int c = 0; c < 2; c++) begin
      if (e >= 2 && stb[c][e-1] && !stb[c][e-2]) m_pend[c] = 1;
      stb[c][e] = stb[c][e-1];
      if (e >= DEB) begin
        all = 1;
        for (int m = e - DEB; m < e; m++) if (sync_at(c, m) == stb[c][e-1]) all = 0;
        if (all) stb[c][e] = ~stb[c][e-1];
      end
    end
    m_busy = (e >= m_start) && (e <= m_start + PUL + GAP - 1);
  endtask

  function automatic logic [4:0] exp_o();
    logic s, r;
    s = m_busy &&  m_cmd && (e <= m_start + PUL - 1);
    r = m_busy && !m_cmd && (e <= m_start + PUL - 1);
    return {s, r, m_busy, m_err, m_last};
  endfunction

  // Drive one cycle from a negedge, update latch + model, return at next negedge.
  task automatic tick(input bit sb, input bit rb, input bit r);
    set_btn = sb; reset_btn = rb; rst = r;
    if (stuck)               q_fb = 1'b0;
    else if (s_out === 1'b1) q_fb = 1'b1;
    else if (r_out === 1'b1) q_fb = 1'b0;
    model_step(r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rst();
    tick(0, 0, 1);
    tick(0, 0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== 5'b0) begin
        n_fail++; $display("FAIL reset_outputs: got %b want 00000", {s_out, r_out, busy, err, last_cmd});
      end
    end
  endtask

  task automatic test_clean_set();
    do_rst();
    for (int k = 1; k <= 16; k++) begin
      tick(1, 0, 0);
      n_chk++;
      if (s_out !== (k == 8 || k == 9)) begin
        n_fail++; $display("FAIL clean_set_s edge %0d: got %b", k, s_out);
      end
      n_chk++;
      if (busy !== (k >= 8 && k <= 12)) begin
        n_fail++; $display("FAIL clean_set_busy edge %0d: got %b", k, busy);
      end
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL clean_set_model edge %0d: got %b want %b", k, {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
    n_chk++;
    if ({last_cmd, err, q_fb} !== 3'b101) begin
      n_fail++; $display("FAIL clean_set_final last/err/q: got %b want 101", {last_cmd, err, q_fb});
    end
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0);
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL clean_release_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
  endtask

  task automatic test_bounce();
    bit lvl;
    int left;
    lvl = 0; left = 0;
    do_rst();
    for (int k = 0; k < 40; k++) begin
      if (k >= 30) lvl = 0;
      else if (left == 0) begin lvl = ~lvl; left = $urandom_range(1, 3); end
      left--;
      tick(lvl, 0, 0);
      n_chk++;
      if ({s_out, r_out, busy} !== 3'b000) begin
        n_fail++; $display("FAIL bounce_quiet cycle %0d: got s/r/busy %b want 000", k, {s_out, r_out, busy});
      end
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL bounce_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
  endtask

  task automatic test_simultaneous();
    int ns, nr, hold;
    ns = 0; nr = 0; hold = 20 + $urandom_range(0, 5);
    do_rst();
    for (int k = 0; k < hold + 12; k++) begin
      tick(k < hold, k < hold, 0);
      ns += int'(s_out); nr += int'(r_out);
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL simul_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
    n_chk++;
    if (nr !== 2 || ns !== 0) begin
      n_fail++; $display("FAIL simul_counts: got r=%0d s=%0d want r=2 s=0", nr, ns);
    end
    n_chk++;
    if (last_cmd !== 1'b0) begin
      n_fail++; $display("FAIL simul_last_cmd: got %b want 0", last_cmd);
    end
  endtask

  task automatic test_queued();
    for (int v = 0; v < 2; v++) begin
      int ns, nr, last_s, first_r;
      ns = 0; nr = 0; last_s = 0; first_r = 0;
      do_rst();
      for (int k = 1; k <= 44; k++) begin
        bit rb;
        rb = (v == 0) ? (k >= 9 && k <= 30) : (k >= 2 && k <= 30);
        tick(k <= 30, rb, 0);
        if (s_out) begin ns++; last_s = k; end
        if (r_out) begin nr++; if (first_r == 0) first_r = k; end
        n_chk++;
        if (s_out && r_out) begin
          n_fail++; $display("FAIL queued_exclusive edge %0d: s and r both 1", k);
        end
        n_chk++;
        if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
          n_fail++; $display("FAIL queued_model v%0d edge %0d: got %b want %b", v, k, {s_out, r_out, busy, err, last_cmd}, exp_o());
        end
      end
      n_chk++;
      if (ns !== 2 || nr !== 2 || first_r - last_s - 1 < GAP + 1) begin
        n_fail++; $display("FAIL queued_shape v%0d: got s=%0d r=%0d gap=%0d want 2 2 >=%0d", v, ns, nr, first_r - last_s - 1, GAP + 1);
      end
      if (v == 1) begin
        n_chk++;
        if (last_s !== 9 || first_r !== 14) begin
          n_fail++; $display("FAIL queued_timing: got last_s=%0d first_r=%0d want 9 14", last_s, first_r);
        end
      end
    end
  endtask

  task automatic test_stuck();
    int sb_t[5], rb_t[5], len_t[5];
    sb_t  = '{0, 0, 0, 1, 0};
    rb_t  = '{0, 1, 0, 0, 0};
    len_t = '{10, 20, 10, 20, 10};
    do_rst();
    stuck = 1;
    for (int k = 1; k <= 20; k++) begin
      tick(1, 0, 0);
      if (k == 12 || k == 13) begin
        n_chk++;
        if (err !== (k == 13)) begin
          n_fail++; $display("FAIL stuck_err_edge %0d: got %b want %b", k, err, k == 13);
        end
      end
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL stuck_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
    stuck = 0;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < len_t[p]; k++) begin
        tick(sb_t[p] != 0, rb_t[p] != 0, 0);
        n_chk++;
        if (err !== 1'b1) begin
          n_fail++; $display("FAIL stuck_err_sticky phase %0d: got %b want 1", p, err);
        end
        n_chk++;
        if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
          n_fail++; $display("FAIL stuck_after_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
        end
      end
    end
  endtask

  task automatic test_midpulse_reset();
    do_rst();
    for (int k = 1; k <= 8; k++) tick(1, 0, 0);
    n_chk++;
    if (s_out !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_s: got %b want 1", s_out);
    end
    tick(1, 0, 1);
    n_chk++;
    if ({s_out, r_out, busy, err, last_cmd} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b want 00000", {s_out, r_out, busy, err, last_cmd});
    end
    for (int k = 1; k <= 14; k++) begin
      tick(1, 0, 0);
      n_chk++;
      if (s_out !== (k == 8 || k == 9)) begin
        n_fail++; $display("FAIL mid_repress_s edge %0d: got %b", k, s_out);
      end
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL mid_model: got %b want %b", {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
  endtask

  task automatic test_random();
    bit sb, rb;
    int ls, lr;
    sb = 0; rb = 0; ls = 0; lr = 0;
    do_rst();
    for (int k = 0; k < 1500; k++) begin
      if (ls == 0) begin sb = 1'($urandom_range(0, 1)); ls = $urandom_range(1, 12); end
      if (lr == 0) begin rb = 1'($urandom_range(0, 1)); lr = $urandom_range(1, 12); end
      ls--; lr--;
      stuck = (k >= 700 && k < 900);
      tick(sb, rb, $urandom_range(0, 299) == 0);
      n_chk++;
      if (s_out && r_out) begin
        n_fail++; $display("FAIL random_exclusive cycle %0d", k);
      end
      n_chk++;
      if ({s_out, r_out, busy, err, last_cmd} !== exp_o()) begin
        n_fail++; $display("FAIL random_model cycle %0d: got %b want %b", k, {s_out, r_out, busy, err, last_cmd}, exp_o());
      end
    end
    stuck = 0;
  endtask

  initial begin
    rst = 1'b1; set_btn = 1'b0; reset_btn = 1'b0; q_fb = 1'b0;
    model_step(1);
    @(negedge clk);
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_queued();
    test_stuck();
    test_midpulse_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
